// File: rtl/video_color_pkg.sv
// Shared definitions for the palette-to-RGB back end: field layout, gate states,
// pipeline depth and the colour-bar generator.
package video_color_pkg;

    localparam int PIPE_DEPTH = 3;
    localparam int CH_W       = 4;
    localparam int HCOUNT_W   = 9;

    localparam int I_LSB = 12;
    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;

    localparam logic [CH_W-1:0] TEST_INTENSITY = 4'hF;

    typedef enum logic [1:0] {
        WAIT_VB,
        IN_VB,
        RUN
    } gate_state_t;

    // Bar index bit 0 lights red, bit 1 green, bit 2 blue, all at full intensity.
    function automatic logic [15:0] test_word(input logic [2:0] bar);
        return {TEST_INTENSITY, {4{bar[0]}}, {4{bar[1]}}, {4{bar[2]}}};
    endfunction

endpackage

// File: rtl/intensity_scale.sv
// One colour channel: scales a 4-bit level by (I+1)/16 after expanding it to 8 bits,
// as a product stage followed by a shift/blanking stage.
module intensity_scale
    import video_color_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [CH_W-1:0] c,
    input  logic [CH_W-1:0] i,
    input  logic            kill,
    output logic [7:0]      out
);

    logic [7:0]  c17;
    logic [4:0]  i_plus;
    logic [11:0] product;

    // c*17 is the nibble replicated; the 12-bit product cannot exceed 255*16.
    assign c17    = {c, c};
    assign i_plus = {1'b0, i} + 5'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            product <= '0;
            out     <= '0;
        end else if (en) begin
            product <= 12'(c17) * 12'(i_plus);
            out     <= kill ? '0 : product[11:4];
        end
    end

endmodule

// File: rtl/video_color_out.sv
// Palette word to 8-bit RGB with blank/sync kept aligned through a 3-strobe pipeline,
// a start-of-frame gate and a colour-bar test source.
module video_color_out
    import video_color_pkg::*;
(
    input  logic        MCKF,
    input  logic        reset,
    input  logic        PIXEN,
    input  logic [15:0] D,
    input  logic        HBLANK_b,
    input  logic        VBLANK_b,
    input  logic        HSYNC_b,
    input  logic        VSYNC_b,
    input  logic        TEST,
    output logic [7:0]  R_out,
    output logic [7:0]  G_out,
    output logic [7:0]  B_out,
    output logic        BLANK_out_b,
    output logic        HSYNC_out_b,
    output logic        VSYNC_out_b,
    output logic        frame_ok
);

    gate_state_t           state_q, state_d;
    logic [HCOUNT_W-1:0]   hcount;
    logic [15:0]           pix_word, word_s1;
    logic [PIPE_DEPTH-1:0] blank_d, hs_d, vs_d;
    logic                  blank_in, kill;

    assign blank_in = ~HBLANK_b | ~VBLANK_b;
    assign pix_word = TEST ? test_word(hcount[HCOUNT_W-1 -: 3]) : D;

    // Stage-1 capture plus the blank/sync delay line; bit 0 lines up with word_s1.
    always_ff @(posedge MCKF) begin
        if (reset) begin
            word_s1 <= '0;
            blank_d <= '1;
            hs_d    <= '1;
            vs_d    <= '1;
            hcount  <= '0;
        end else if (PIXEN) begin
            word_s1 <= pix_word;
            blank_d <= {blank_d[PIPE_DEPTH-2:0], blank_in};
            hs_d    <= {hs_d[PIPE_DEPTH-2:0], HSYNC_b};
            vs_d    <= {vs_d[PIPE_DEPTH-2:0], VSYNC_b};
            if (!HBLANK_b)
                hcount <= '0;
            else if (!blank_in && hcount != '1)
                hcount <= hcount + 1'b1;
        end
    end

    always_ff @(posedge MCKF) begin
        if (reset)
            state_q <= WAIT_VB;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (PIXEN) begin
            case (state_q)
                WAIT_VB: if (!VBLANK_b) state_d = IN_VB;
                IN_VB:   if (VBLANK_b)  state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = WAIT_VB;
            endcase
        end
    end

    // Stage 3 sees the blank bit of the pixel sitting in the product registers.
    assign kill     = blank_d[PIPE_DEPTH-2] | (state_q != RUN);
    assign frame_ok = (state_q == RUN);

    intensity_scale u_red (
        .clk   (MCKF),
        .reset (reset),
        .en    (PIXEN),
        .c     (word_s1[R_LSB +: CH_W]),
        .i     (word_s1[I_LSB +: CH_W]),
        .kill  (kill),
        .out   (R_out)
    );

    intensity_scale u_green (
        .clk   (MCKF),
        .reset (reset),
        .en    (PIXEN),
        .c     (word_s1[G_LSB +: CH_W]),
        .i     (word_s1[I_LSB +: CH_W]),
        .kill  (kill),
        .out   (G_out)
    );

    intensity_scale u_blue (
        .clk   (MCKF),
        .reset (reset),
        .en    (PIXEN),
        .c     (word_s1[B_LSB +: CH_W]),
        .i     (word_s1[I_LSB +: CH_W]),
        .kill  (kill),
        .out   (B_out)
    );

    assign BLANK_out_b = ~blank_d[PIPE_DEPTH-1];
    assign HSYNC_out_b = hs_d[PIPE_DEPTH-1];
    assign VSYNC_out_b = vs_d[PIPE_DEPTH-1];

endmodule

// File: tb/tb_video_color_out.sv
// Self-checking bench for video_color_out: a per-pixel reference model built from the
// scaling formula and frame-gate rules, plus table vectors and hand-written corner cases.
module tb_video_color_out;
    import video_color_pkg::*;

    logic        MCKF = 1'b0;
    logic        reset = 1'b1;
    logic        PIXEN = 1'b0;
    logic [15:0] D = '0;
    logic        HBLANK_b = 1'b1;
    logic        VBLANK_b = 1'b1;
    logic        HSYNC_b = 1'b1;
    logic        VSYNC_b = 1'b1;
    logic        TEST = 1'b0;
    logic [7:0]  R_out, G_out, B_out;
    logic        BLANK_out_b, HSYNC_out_b, VSYNC_out_b, frame_ok;

    video_color_out dut (
        .MCKF        (MCKF),
        .reset       (reset),
        .PIXEN       (PIXEN),
        .D           (D),
        .HBLANK_b    (HBLANK_b),
        .VBLANK_b    (VBLANK_b),
        .HSYNC_b     (HSYNC_b),
        .VSYNC_b     (VSYNC_b),
        .TEST        (TEST),
        .R_out       (R_out),
        .G_out       (G_out),
        .B_out       (B_out),
        .BLANK_out_b (BLANK_out_b),
        .HSYNC_out_b (HSYNC_out_b),
        .VSYNC_out_b (VSYNC_out_b),
        .frame_ok    (frame_ok)
    );

    always #5 MCKF = ~MCKF;

    typedef struct {
        logic [7:0] r, g, b;
        logic       blank, hs, vs;
    } pix_t;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  r, g, b;
    } vec_t;

    int checks = 0;
    int passes = 0;

    // Reference model state: pixels in flight, line position and frame-gate booleans.
    pix_t       pipe[$];
    int         hmodel;
    bit         seen_vblank, running;
    logic [7:0] exp_r, exp_g, exp_b;
    logic       exp_blank_b, exp_hs, exp_vs;

    function automatic int scale(input int c, input int i);
        return (c * 17 * (i + 1)) / 16;
    endfunction

    function automatic pix_t black();
        pix_t p;
        p.r = 0; p.g = 0; p.b = 0;
        p.blank = 1'b1; p.hs = 1'b1; p.vs = 1'b1;
        return p;
    endfunction

    task automatic modelStep();
        pix_t        p, head;
        logic [15:0] w;
        int          bar;
        bit          visible;
        if (reset) begin
            pipe = {};
            for (int k = 0; k < PIPE_DEPTH - 1; k++) pipe.push_back(black());
            hmodel = 0; seen_vblank = 0; running = 0;
            exp_r = 0; exp_g = 0; exp_b = 0;
            exp_blank_b = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
        end else if (PIXEN) begin
            visible = running;
            bar = hmodel / 64;
            w = TEST ? {4'hF, (bar % 2) ? 4'hF : 4'h0, ((bar / 2) % 2) ? 4'hF : 4'h0,
                        ((bar / 4) % 2) ? 4'hF : 4'h0} : D;
            p.r = 8'(scale(int'(w[11:8]), int'(w[15:12])));
            p.g = 8'(scale(int'(w[7:4]), int'(w[15:12])));
            p.b = 8'(scale(int'(w[3:0]), int'(w[15:12])));
            p.blank = !HBLANK_b || !VBLANK_b;
            p.hs = HSYNC_b;
            p.vs = VSYNC_b;
            pipe.push_back(p);
            head = pipe.pop_front();
            exp_r = (head.blank || !visible) ? 8'd0 : head.r;
            exp_g = (head.blank || !visible) ? 8'd0 : head.g;
            exp_b = (head.blank || !visible) ? 8'd0 : head.b;
            exp_blank_b = !head.blank;
            exp_hs = head.hs;
            exp_vs = head.vs;
            if (!HBLANK_b) hmodel = 0;
            else if (VBLANK_b && hmodel < 511) hmodel++;
            if (!seen_vblank) begin
                if (!VBLANK_b) seen_vblank = 1;
            end else if (VBLANK_b) begin
                running = 1;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    endtask

    // Drive one cycle at the falling edge, then compare every output to the model.
    task automatic applyStimulus(input logic rst, input logic pixen, input logic [15:0] d,
                                 input logic hb, input logic vb, input logic hs,
                                 input logic vs, input logic test);
        @(negedge MCKF);
        reset = rst; PIXEN = pixen; D = d;
        HBLANK_b = hb; VBLANK_b = vb; HSYNC_b = hs; VSYNC_b = vs; TEST = test;
        @(posedge MCKF);
        modelStep();
        #1;
        checkOutput("rgb", 32'({R_out, G_out, B_out}), 32'({exp_r, exp_g, exp_b}));
        checkOutput("ctrl", 32'({BLANK_out_b, HSYNC_out_b, VSYNC_out_b, frame_ok}),
                    32'({exp_blank_b, exp_hs, exp_vs, logic'(running)}));
    endtask

    task automatic strobe(input logic [15:0] d, input logic hb, input logic vb,
                          input logic hs, input logic test);
        applyStimulus(1'b0, 1'b1, d, hb, vb, hs, 1'b1, test);
    endtask

    task automatic fullVblank();
        for (int k = 0; k < 3; k++) strobe(16'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        strobe(16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    vec_t        vecs[6];
    logic [23:0] bars[8];

    initial begin
        vecs[0] = '{16'hFF08, 8'd255, 8'd0,   8'd136};
        vecs[1] = '{16'h0FFF, 8'd15,  8'd15,  8'd15};
        vecs[2] = '{16'h7A51, 8'd85,  8'd42,  8'd8};
        vecs[3] = '{16'h0000, 8'd0,   8'd0,   8'd0};
        vecs[4] = '{16'hF0F0, 8'd0,   8'd255, 8'd0};
        vecs[5] = '{16'h3C96, 8'd51,  8'd38,  8'd25};
        bars[0] = 24'h000000; bars[1] = 24'hFF0000; bars[2] = 24'h00FF00; bars[3] = 24'hFFFF00;
        bars[4] = 24'h0000FF; bars[5] = 24'hFF00FF; bars[6] = 24'h00FFFF; bars[7] = 24'hFFFFFF;

        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("reset_blank_b", 32'(BLANK_out_b), 32'd0);

        // No VBLANK seen yet: colour stays black while syncs still travel.
        for (int k = 0; k < 10; k++) strobe(16'hFFFF, 1'b1, 1'b1, logic'(k % 2), 1'b0);
        checkOutput("gate_closed_rgb", 32'({R_out, G_out, B_out}), 32'd0);
        checkOutput("gate_closed_ok", 32'(frame_ok), 32'd0);

        fullVblank();
        checkOutput("frame_ok_after_vb", 32'(frame_ok), 32'd1);

        for (int s = 0; s < 6 + 2; s++) begin
            strobe((s < 6) ? vecs[s].d : 16'h0, 1'b1, 1'b1, 1'b1, 1'b0);
            if (s >= 2)
                checkOutput($sformatf("vec%0d", s - 2), 32'({R_out, G_out, B_out}),
                            32'({vecs[s - 2].r, vecs[s - 2].g, vecs[s - 2].b}));
        end

        // One 512-pixel colour-bar line, output for pixel p appears at strobe p+2.
        strobe(16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int s = 0; s < 512 + 2; s++) begin
            strobe(16'h1234, 1'b1, 1'b1, 1'b1, (s < 512) ? 1'b1 : 1'b0);
            if (s >= 2 && ((s - 2) % 64) == 32)
                checkOutput($sformatf("bar%0d", (s - 2) / 64), 32'({R_out, G_out, B_out}),
                            32'(bars[(s - 2) / 64]));
        end

        // Gapped pixel strobe, one in four cycles, with a toggling hsync.
        for (int k = 0; k < 48; k++)
            applyStimulus(1'b0, logic'(k % 4 == 0), 16'($urandom), 1'b1, 1'b1,
                          logic'((k / 8) % 2), 1'b1, 1'b0);

        for (int k = 0; k < 300; k++)
            applyStimulus(1'b0, logic'($urandom_range(0, 1)), 16'($urandom),
                          logic'($urandom % 16 != 0), logic'($urandom % 32 != 0),
                          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                          logic'($urandom % 4 == 0));

        // Mid-line reset while running, with VBLANK_b held low across the release.
        fullVblank();
        strobe(16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("midreset_rgb", 32'({R_out, G_out, B_out}), 32'd0);
        checkOutput("midreset_syncs", 32'({HSYNC_out_b, VSYNC_out_b}), 32'b11);
        checkOutput("midreset_ok", 32'(frame_ok), 32'd0);
        for (int k = 0; k < 6; k++) strobe(16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("post_reset_rgb", 32'({R_out, G_out, B_out}), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        strobe(16'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("vb_low_release_ok", 32'(frame_ok), 32'd0);
        for (int k = 0; k < 4; k++) strobe(16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("recovered_ok", 32'(frame_ok), 32'd1);
        checkOutput("recovered_rgb", 32'({R_out, G_out, B_out}), 32'hFFFFFF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
